alu_result_fifo: RTL and testbench

- Downstream capture stage for the 8-bit ALU.
- Accepts the ALU's 9-bit result (8-bit data plus carry/borrow in bit 8) and the 4-bit select that produced it, using a valid/ready handshake.
- Derives carry/zero/negative flags and buffers {sel, flags, data} in a small show-ahead FIFO for the consumer (register file or write-back stage).
- Decouples the combinational ALU from a consumer that can stall.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_flag_gen.sv | 19 +
 rtl/alu_result_fifo.sv | 117 +++++++++++
 tb/tb_alu_result_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, select opcodes, captured-result layout and
// a helper that computes the flags.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] OP_ADD  = 4'h0;
  localparam logic [SEL_W-1:0] OP_SUB  = 4'h1;
  localparam logic [SEL_W-1:0] OP_AND  = 4'h2;
  localparam logic [SEL_W-1:0] OP_OR   = 4'h3;
  localparam logic [SEL_W-1:0] OP_XOR  = 4'h4;
  localparam logic [SEL_W-1:0] OP_NOT  = 4'h5;
  localparam logic [SEL_W-1:0] OP_SHL  = 4'h6;
  localparam logic [SEL_W-1:0] OP_SHR  = 4'h7;
  localparam logic [SEL_W-1:0] OP_INC  = 4'h8;
  localparam logic [SEL_W-1:0] OP_DEC  = 4'h9;
  localparam logic [SEL_W-1:0] OP_ADC  = 4'hA;
  localparam logic [SEL_W-1:0] OP_SBB  = 4'hB;
  localparam logic [SEL_W-1:0] OP_NAND = 4'hC;
  localparam logic [SEL_W-1:0] OP_NOR  = 4'hD;
  localparam logic [SEL_W-1:0] OP_PASA = 4'hE;
  localparam logic [SEL_W-1:0] OP_PASB = 4'hF;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic              carry;
    logic              zero;
    logic              neg;
    logic [DATA_W-1:0] data;
  } alu_res_t;

  // Returns {carry, zero, neg}; zero looks at the data bits only.
  function automatic logic [2:0] alu_flags(input logic [DATA_W:0] result);
    return {result[DATA_W], (result[DATA_W-1:0] == '0), result[DATA_W-1]};
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational carry/zero/negative flag derivation from an ALU result.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic [DATA_W:0] result,
  output logic            carry,
  output logic            zero,
  output logic            neg
);

  always_comb begin
    carry = result[DATA_W];
    zero  = (result[DATA_W-1:0] == '0);
    neg   = result[DATA_W-1];
  end

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead capture FIFO for ALU results with derived flags and a sticky
// back-pressure indicator.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int SEL_W  = alu_pkg::SEL_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W:0]           in_result,
  input  logic [SEL_W-1:0]          in_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_carry,
  output logic                      out_zero,
  output logic                      out_neg,
  output logic [SEL_W-1:0]          out_sel,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      stall_seen
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic              carry;
    logic              zero;
    logic              neg;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             f_carry;
  logic             f_zero;
  logic             f_neg;
  entry_t           wr_entry;
  entry_t           head;

  alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .result (in_result),
    .carry  (f_carry),
    .zero   (f_zero),
    .neg    (f_neg)
  );

  // Handshake status comes from registered occupancy only, so a pop never
  // frees a slot for a push in the same cycle.
  always_comb begin
    in_ready  = (count != FULL_CNT);
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.sel   = in_sel;
    wr_entry.carry = f_carry;
    wr_entry.zero  = f_zero;
    wr_entry.neg   = f_neg;
    wr_entry.data  = in_result[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stall_seen <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (in_valid && !in_ready) begin
        stall_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem[rd_ptr];
    end
    out_data  = head.data;
    out_carry = head.carry;
    out_zero  = head.zero;
    out_neg   = head.neg;
    out_sel   = head.sel;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_result;
  logic [3:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;
  logic       out_zero;
  logic       out_neg;
  logic [3:0] out_sel;
  logic [2:0] count;
  logic       stall_seen;

  int checks   = 0;
  int failures = 0;

  alu_result_fifo #(.DATA_W(8), .SEL_W(4), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_sel    (out_sel),
    .count      (count),
    .stall_seen (stall_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of raw results, flags derived on the fly.
  typedef struct {
    int unsigned result;
    int unsigned sel;
  } item_t;

  item_t q[$];
  bit    m_stall   = 1'b0;
  bit    m_live    = 1'b0;
  int    pushed_n  = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_stall = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (in_valid && q.size() == DEPTH) m_stall = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        item_t it;
        it.result = int'(in_result);
        it.sel    = int'(in_sel);
        q.push_back(it);
        pushed_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      int unsigned d, c, z, n, s;
      d = 0; c = 0; z = 0; n = 0; s = 0;
      if (q.size() > 0) begin
        d = q[0].result % 256;
        c = (q[0].result >= 256) ? 1 : 0;
        z = (d == 0) ? 1 : 0;
        n = (d >= 128) ? 1 : 0;
        s = q[0].sel;
      end
      check("m_count",     32'(count),      32'(q.size()));
      check("m_out_valid", 32'(out_valid),  (q.size() > 0) ? 1 : 0);
      check("m_in_ready",  32'(in_ready),   (q.size() < DEPTH) ? 1 : 0);
      check("m_stall",     32'(stall_seen), 32'(m_stall));
      check("m_data",      32'(out_data),   d);
      check("m_carry",     32'(out_carry),  c);
      check("m_zero",      32'(out_zero),   z);
      check("m_neg",       32'(out_neg),    n);
      check("m_sel",       32'(out_sel),    s);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push1(input logic [8:0] r, input logic [3:0] s);
    in_valid  = 1'b1;
    in_result = r;
    in_sel    = s;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic head_is(input string name, input logic [7:0] d, input logic c,
                         input logic z, input logic n);
    check({name, "_data"},  32'(out_data),  32'(d));
    check({name, "_carry"}, 32'(out_carry), 32'(c));
    check({name, "_zero"},  32'(out_zero),  32'(z));
    check({name, "_neg"},   32'(out_neg),   32'(n));
  endtask

  initial begin
    int cyc;
    int sent;
    logic [8:0] vals [10];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_result = '0; in_sel = '0;
    tick();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);

    // Flags from 0xB5 + 0xE7
    push1(9'h19C, OP_ADD);
    head_is("t1", 8'h9C, 1'b1, 1'b0, 1'b1);
    check("t1_sel", 32'(out_sel), 0);
    check("t1_count", 32'(count), 1);
    pop1();

    // Zero flag ignores carry
    push1(9'h100, OP_SUB);
    push1(9'h000, OP_AND);
    push1(9'h07F, OP_OR);
    head_is("t2a", 8'h00, 1'b1, 1'b1, 1'b0);
    pop1();
    head_is("t2b", 8'h00, 1'b0, 1'b1, 1'b0);
    pop1();
    head_is("t2c", 8'h7F, 1'b0, 1'b0, 1'b0);
    check("t2c_sel", 32'(out_sel), 3);
    pop1();
    check("t2_empty", 32'(out_valid), 0);

    // Fill past capacity
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_result = 9'(i);
      in_sel    = 4'(i);
      tick();
      if (i == 4) check("t3_full_count", 32'(count), 4);
    end
    in_valid = 1'b0;
    check("t3_in_ready", 32'(in_ready), 0);
    check("t3_stall", 32'(stall_seen), 1);
    for (int i = 1; i <= 4; i++) begin
      check("t3_drain", 32'(out_data), 32'(i));
      pop1();
    end
    check("t3_drained", 32'(out_valid), 0);

    // Concurrent push/pop at occupancy 2 across pointer wrap
    push1(9'h010, OP_XOR);
    push1(9'h011, OP_XOR);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_result = 9'(16 + 1 + i);
      tick();
      check("t4_count", 32'(count), 2);
      check("t4_head", 32'(out_data), 32'(16 + i));
    end
    in_valid = 1'b0;
    pop1();
    check("t4_tail0", 32'(out_data), 8'h17);
    pop1();
    check("t4_empty", 32'(count), 0);

    // Stream 10 results with random consumer stalls
    for (int i = 0; i < 10; i++) vals[i] = 9'(37 * i + 200);
    pushed_n = 0;
    sent = 0;
    cyc = 0;
    while ((sent < 10 || count != 0) && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      in_result = (sent < 10) ? vals[sent] : 9'h0;
      in_sel    = 4'(sent);
      @(posedge clk);
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      if (count > 3'd4) check("t5_count_max", 32'(count), 4);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("t5_timeout", (cyc < 300) ? 1 : 0, 1);
    check("t5_pushed", 32'(pushed_n), 10);

    // Reset mid-operation
    push1(9'h001, OP_INC);
    push1(9'h002, OP_INC);
    push1(9'h003, OP_INC);
    check("t6_pre_count", 32'(count), 3);
    check("t6_pre_stall", 32'(stall_seen), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_count", 32'(count), 0);
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_in_ready", 32'(in_ready), 1);
    check("t6_stall", 32'(stall_seen), 0);
    head_is("t6_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    check("t6_idle_sel", 32'(out_sel), 0);
    push1(9'h0AA, OP_PASA);
    head_is("t6_push", 8'hAA, 1'b0, 1'b0, 1'b1);
    check("t6_push_sel", 32'(out_sel), 32'hE);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
